// File: rtl/fetch_aligner_pkg.sv
// Shared decode-stage constants and fetch-aligner FSM encoding.
package fetch_aligner_pkg;

  localparam int BUF_BYTES    = 32;
  localparam int PKT_BYTES    = 16;
  localparam int MAX_INSN_LEN = 15;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fetch_aligner_byte_shifter.sv
// Combinational left shift of a byte buffer by 0..15 bytes, zero fill.
// No latency, no state, no backpressure.
module byte_shifter #(
  parameter int W = 256
) (
  input  logic [W-1:0] din,
  input  logic [3:0]   shamt,
  output logic [W-1:0] dout
);

  assign dout = din << {shamt, 3'b000};

endmodule

// File: rtl/fetch_aligner.sv
// Packs fetch lines into a left-aligned byte buffer and presents a decode window.
// One-cycle latency; fill_ready only while buffer holds <= one window of bytes.
module fetch_aligner #(
  parameter int BUF_BYTES = fetch_aligner_pkg::BUF_BYTES,
  parameter int PKT_BYTES = fetch_aligner_pkg::PKT_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_eip,
  input  logic                   fill_valid,
  output logic                   fill_ready,
  input  logic [PKT_BYTES*8-1:0] fill_data,
  output logic [PKT_BYTES*8-1:0] packet,
  output logic                   packet_valid,
  output logic [31:0]            packet_eip,
  input  logic                   dec_take,
  input  logic [3:0]             dec_len,
  output logic                   len_err
);
  import fetch_aligner_pkg::*;

  localparam int BW = BUF_BYTES * 8;
  localparam int PW = PKT_BYTES * 8;
  localparam int CW = $clog2(BUF_BYTES + 1);

  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d, shifted, fill_ext;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_after;
  logic [31:0]     eip_q, eip_d;
  logic            err_q, err_d;
  logic            run, consume, zero_take, fill_fire;
  logic [3:0]      shamt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_WAIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    run          = (state_q == ST_RUN);
    fill_ready   = run && (cnt_q <= CW'(PKT_BYTES));
    packet_valid = run && (cnt_q >= CW'(PKT_BYTES));
    if (redirect_valid) state_d = ST_RUN;
  end

  assign consume   = dec_take & packet_valid & (dec_len != 4'd0);
  assign zero_take = dec_take & packet_valid & (dec_len == 4'd0);
  assign fill_fire = fill_valid & fill_ready;
  assign shamt     = consume ? dec_len : 4'd0;
  assign cnt_after = cnt_q - CW'(shamt);

  byte_shifter #(.W(BW)) u_shift (
    .din   (buf_q),
    .shamt (shamt),
    .dout  (shifted)
  );

  // New line lands directly behind whatever survives this cycle's consume.
  assign fill_ext = {fill_data, {(BW - PW){1'b0}}} >> {cnt_after, 3'b000};

  always_comb begin
    buf_d = shifted;
    cnt_d = cnt_after;
    eip_d = eip_q + 32'(shamt);
    err_d = err_q | zero_take;
    if (fill_fire) begin
      buf_d = shifted | fill_ext;
      cnt_d = cnt_after + CW'(PKT_BYTES);
    end
    if (redirect_valid) begin
      buf_d = '0;
      cnt_d = '0;
      eip_d = redirect_eip;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q <= '0;
      cnt_q <= '0;
      eip_q <= '0;
      err_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      eip_q <= eip_d;
      err_q <= err_d;
    end
  end

  assign packet     = buf_q[BW-1 -: PW];
  assign packet_eip = eip_q;
  assign len_err    = err_q;

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed and random stimulus against a byte-queue reference model.
module tb_fetch_aligner;

  logic         clk = 1'b0;
  logic         reset;
  logic         redirect_valid;
  logic [31:0]  redirect_eip;
  logic         fill_valid;
  logic         fill_ready;
  logic [127:0] fill_data;
  logic [127:0] packet;
  logic         packet_valid;
  logic [31:0]  packet_eip;
  logic         dec_take;
  logic [3:0]   dec_len;
  logic         len_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] pkt;
    logic         pv;
    logic         fr;
    logic [31:0]  eip;
    logic         err;
    int           cnt;
  } exp_t;

  exp_t        sb[$];
  byte unsigned mbuf[$];
  logic [31:0] meip;
  logic        merr;
  logic        mrun;

  fetch_aligner dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_eip   (redirect_eip),
    .fill_valid     (fill_valid),
    .fill_ready     (fill_ready),
    .fill_data      (fill_data),
    .packet         (packet),
    .packet_valid   (packet_valid),
    .packet_eip     (packet_eip),
    .dec_take       (dec_take),
    .dec_len        (dec_len),
    .len_err        (len_err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] line(input logic [7:0] base);
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[127-8*i -: 8] = base + 8'(i);
    return d;
  endfunction

  function automatic exp_t model_view();
    exp_t e;
    e.pkt = '0;
    for (int i = 0; i < 16; i++)
      if (i < mbuf.size()) e.pkt[127-8*i -: 8] = mbuf[i];
    e.pv  = mrun && (mbuf.size() >= 16);
    e.fr  = mrun && (mbuf.size() <= 16);
    e.eip = meip;
    e.err = merr;
    e.cnt = mbuf.size();
    return e;
  endfunction

  task automatic model_reset();
    mbuf.delete();
    meip = '0;
    merr = 1'b0;
    mrun = 1'b0;
  endtask

  task automatic model_clock();
    int  n;
    logic pv, fr;
    if (!reset) begin
      model_reset();
    end else if (redirect_valid) begin
      mbuf.delete();
      meip = redirect_eip;
      merr = 1'b0;
      mrun = 1'b1;
    end else if (mrun) begin
      n  = mbuf.size();
      pv = (n >= 16);
      fr = (n <= 16);
      if (dec_take && pv) begin
        if (dec_len == 4'd0) merr = 1'b1;
        else begin
          for (int k = 0; k < int'(dec_len); k++) void'(mbuf.pop_front());
          meip = meip + 32'(dec_len);
        end
      end
      if (fill_valid && fr)
        for (int i = 0; i < 16; i++) mbuf.push_back(fill_data[127-8*i -: 8]);
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp_pop();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("packet",       packet,                e.pkt);
      chk("packet_valid", 128'(packet_valid),    128'(e.pv));
      chk("fill_ready",   128'(fill_ready),      128'(e.fr));
      chk("packet_eip",   128'(packet_eip),      128'(e.eip));
      chk("len_err",      128'(len_err),         128'(e.err));
      chk("cnt",          128'(dut.cnt_q),       128'(e.cnt));
    end
  endtask

  task automatic step(input logic rv, input logic [31:0] reip, input logic fv,
                      input logic [127:0] fd, input logic tk, input logic [3:0] ln);
    redirect_valid = rv;
    redirect_eip   = reip;
    fill_valid     = fv;
    fill_data      = fd;
    dec_take       = tk;
    dec_len        = ln;
    model_clock();
    sb.push_back(model_view());
    @(posedge clk);
    #1;
    cmp_pop();
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 128'h0, 1'b0, 4'd0);
  endtask

  initial begin
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_eip = '0;
    fill_valid = 1'b0;
    fill_data = '0;
    dec_take = 1'b0;
    dec_len = '0;
    model_reset();
    #12;
    sb.push_back(model_view());
    cmp_pop();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // WAIT state: fill and take must be ignored
    step(1'b0, 32'h0, 1'b1, line(8'hA0), 1'b1, 4'd3);
    chk("wait_fill_ready", 128'(fill_ready), 128'(1'b0));

    step(1'b1, 32'h0000_1000, 1'b0, 128'h0, 1'b0, 4'd0);
    step(1'b0, 32'h0, 1'b1, line(8'h00), 1'b0, 4'd0);
    step(1'b0, 32'h0, 1'b1, line(8'h10), 1'b0, 4'd0);
    chk("r034_pv",   128'(packet_valid),    128'(1'b1));
    chk("r034_top",  128'(packet[127:120]), 128'(8'h00));
    chk("r034_eip",  128'(packet_eip),      128'(32'h0000_1000));
    chk("r034_cnt",  128'(dut.cnt_q),       128'(32));
    chk("r034_fr",   128'(fill_ready),      128'(1'b0));

    step(1'b0, 32'h0, 1'b1, line(8'h50), 1'b1, 4'd3);
    chk("r035_top",  128'(packet[127:120]), 128'(8'h03));
    chk("r035_eip",  128'(packet_eip),      128'(32'h0000_1003));
    chk("r035_cnt",  128'(dut.cnt_q),       128'(29));
    chk("r035_fr",   128'(fill_ready),      128'(1'b0));

    step(1'b0, 32'h0, 1'b0, 128'h0, 1'b1, 4'd13);
    step(1'b0, 32'h0, 1'b1, line(8'h20), 1'b1, 4'd15);

    step(1'b1, 32'h0000_4000, 1'b0, 128'h0, 1'b0, 4'd0);
    step(1'b0, 32'h0, 1'b1, line(8'h00), 1'b0, 4'd0);
    step(1'b0, 32'h0, 1'b1, line(8'h20), 1'b1, 4'd15);
    chk("r036_cnt",  128'(dut.cnt_q),       128'(17));
    chk("r036_b0",   128'(packet[127:120]), 128'(8'h0F));
    chk("r036_b1",   128'(packet[119:112]), 128'(8'h20));
    chk("r036_tail", 128'(packet[7:0]),     128'(8'h2E));

    step(1'b0, 32'h0, 1'b0, 128'h0, 1'b1, 4'd0);
    chk("r037_cnt",  128'(dut.cnt_q),       128'(17));
    chk("r037_err",  128'(len_err),         128'(1'b1));
    step(1'b1, 32'h0000_2000, 1'b0, 128'h0, 1'b0, 4'd0);
    chk("r037_err0", 128'(len_err),         128'(1'b0));
    chk("r037_cnt0", 128'(dut.cnt_q),       128'(0));
    chk("r037_pv0",  128'(packet_valid),    128'(1'b0));

    // take while the window is not yet full is silently ignored
    step(1'b0, 32'h0, 1'b0, 128'h0, 1'b1, 4'd0);
    chk("no_err_empty", 128'(len_err), 128'(1'b0));

    step(1'b0, 32'h0, 1'b1, line(8'h60), 1'b0, 4'd0);
    step(1'b1, 32'h0000_5000, 1'b1, line(8'h70), 1'b1, 4'd5);
    chk("r038_cnt",  128'(dut.cnt_q),       128'(0));
    chk("r038_eip",  128'(packet_eip),      128'(32'h0000_5000));

    step(1'b1, 32'hFFFF_FFFE, 1'b0, 128'h0, 1'b0, 4'd0);
    step(1'b0, 32'h0, 1'b1, line(8'h80), 1'b0, 4'd0);
    step(1'b0, 32'h0, 1'b0, 128'h0, 1'b1, 4'd4);
    chk("r039_eip",  128'(packet_eip),      128'(32'h0000_0002));
    chk("r039_top",  128'(packet[127:120]), 128'(8'h84));
    chk("r039_zero", 128'(packet[31:0]),    128'(32'h0));

    for (int i = 0; i < 300; i++) begin
      logic [3:0] ln;
      ln = ($urandom_range(0, 19) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      step($urandom_range(0, 39) == 0, $urandom,
           $urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 2) != 0, ln);
    end

    // asynchronous reset in the middle of traffic
    step(1'b1, 32'h0000_9000, 1'b0, 128'h0, 1'b0, 4'd0);
    step(1'b0, 32'h0, 1'b1, line(8'hC0), 1'b0, 4'd0);
    reset = 1'b0;
    #1;
    model_reset();
    sb.push_back(model_view());
    cmp_pop();
    step(1'b1, 32'h0000_7000, 1'b1, line(8'hD0), 1'b1, 4'd2);
    chk("rst_eip", 128'(packet_eip), 128'(32'h0));
    reset = 1'b1;
    idle();
    step(1'b0, 32'h0, 1'b1, line(8'hE0), 1'b0, 4'd0);
    chk("post_rst_cnt", 128'(dut.cnt_q), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
